mode_select_ctrl: RTL and testbench
===================================

# mode_select_ctrl

Upstream control stage for the VGA test-pattern generator. It turns the raw, bouncing mode push-button into a clean 2-bit display-mode code. Short presses advance the mode; a long press returns to mode 0. Mode changes are applied only at the start of the vertical sync pulse, so the pattern never switches mid-frame. Output drives the pattern generator's mode selection directly, replacing its edge-clocked counter.

## Interface
- DB_CYCLES, 1000000, debounce interval in clk cycles (20 ms at 50 MHz); min 2
- LONG_CYCLES, 50000000, hold time in clk cycles that qualifies a long press (1 s); must exceed DB_CYCLES
- NUM_MODES, 4, number of modes; valid 2..4
- AUTO_FRAMES, 300, frames between auto-advances; used only with MODE_AUTOCYCLE_EN
- clk  in  1  50 MHz pixel clock
- rst  in  1  reset, asynchronous, active-low
- key_n  in  1  raw button, active-low, asynchronous to clk
- vsync  in  1  active-low vsync from the timing generator, synchronous to clk
- mode  out  2  applied display mode, 0..NUM_MODES-1
- mode_chg  out  1  one-cycle pulse in the cycle `mode` takes a new value
- key_evt  out  2  one-cycle event: 2'b01 short press, 2'b10 long press, else 2'b00

## Operation
- key_n passes through a 2-FF synchronizer (reset value 1); `ks` is the synchronizer output.
- Debounce FSM, reset state IDLE; one down-counter is shared by the debounce and long-press timing.
  - IDLE: ks=0 → PRESS_DB, load DB_CYCLES-1.
  - PRESS_DB: ks=1 → IDLE (glitch, no event).
    - Counter reaches 0 with ks=0 → HELD, load LONG_CYCLES-DB_CYCLES-1, clear `long_done`.
  - HELD: counter reaches 0 while ks=0 and !long_done → key_evt=10, set long_done, counter stops.
    - ks=1 → REL_DB, load DB_CYCLES-1.
  - REL_DB: ks=0 → HELD; the long counter restarts from full; long_done is kept.
    - Counter reaches 0 with ks=1 → IDLE; key_evt=01 if !long_done.
- Pending register `pend` (2 bits, reset 0):
  - Short event: pend ← (pend==NUM_MODES-1) ? 0 : pend+1.
  - Long event: pend ← 0.
- Frame edge: vsync_q is vsync registered (reset 1); `vfall` = vsync_q & ~vsync.
- On vfall: mode ← pend, and mode_chg=1 iff pend≠mode.
- Event and vfall in the same cycle: mode takes the pre-event pend; the updated pend applies at the next vfall.
- Counter arithmetic: ceil(log2(LONG_CYCLES)) bits, unsigned, no wrap. Loads are always done before decrementing.

## Timing
- Reset values: mode=0, mode_chg=0, key_evt=00, FSM IDLE, pend=0.
- Reset mid-press: everything returns to the reset values. A key still held after reset release must debounce again from IDLE.
- Press detection: PRESS_DB entered 3 cycles after the key_n fall (2 sync + 1 FSM). HELD is entered DB_CYCLES cycles later.
- Short event: asserted the cycle REL_DB completes, i.e. 2+1+DB_CYCLES cycles after a clean key_n rise.
- Long event: asserted LONG_CYCLES cycles after PRESS_DB entry while held continuously.
- mode and mode_chg update in the cycle after the clock edge where vfall is seen (registered). Worst-case latency from event to mode is one frame.
- key_evt and mode_chg are strictly one cycle wide. Neither repeats while the button is held.

## Configuration
- MODE_AUTOCYCLE_EN defined:
  - A frame counter counts vfall events; it is cleared by any key_evt and on reset.
  - When it reaches AUTO_FRAMES-1, pend advances like a short press and the counter clears. That update lands in the same cycle, so the new pend applies on the following vfall.
  - key_evt is not pulsed for auto-advance.
- Undefined: no frame counter is built; mode changes only by button; AUTO_FRAMES is ignored.

## Test plan
Bench parameters: DB_CYCLES=8, LONG_CYCLES=64, AUTO_FRAMES=3, vsync low 2 cycles every 100.
- Glitches: key_n low 5 cycles then high, repeated 4× → key_evt stays 00, mode stays 0, no mode_chg.
- Short press: key_n low 30 cycles, high → one key_evt=01; at the next vfall mode=1 with a single mode_chg pulse.
- Wrap: 4 clean short presses, each followed by a vfall → mode goes 1,2,3,0, with mode_chg on each step.
- Long press: from mode=2, hold 200 cycles → exactly one key_evt=10 at 64 cycles after PRESS_DB entry. No short event on release; mode=0 at the next vfall.
- Same-cycle collision: short event in the cycle vfall is seen, with mode=pend=1 → mode stays 1 and no mode_chg. pend=2; mode=2 at the following vfall.
- Mid-press reset plus auto-cycle (MODE_AUTOCYCLE_EN):
  - Assert rst during HELD → mode=0, FSM IDLE; the key must debounce again.
  - Then, with no key activity, mode advances once every 3 vfalls.

Source files
------------

// File: rtl/mode_select_ctrl.sv
// mode_select_ctrl: debounced mode button -> frame-aligned 2-bit display mode.
// Optional auto-advance every AUTO_FRAMES frames when MODE_AUTOCYCLE_EN is defined.
module mode_select_ctrl #(
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 50000000,
  parameter int NUM_MODES   = 4,
  parameter int AUTO_FRAMES = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic [1:0] key_evt
);
  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] DB_LOAD = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LOAD = CW'(LONG_CYCLES - DB_CYCLES - 1);
  localparam logic [1:0] LAST = 2'(NUM_MODES - 1);
  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES || NUM_MODES < 2 || NUM_MODES > 4 || AUTO_FRAMES < 1) begin : g_bad_params
    $error("mode_select_ctrl: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic ks;
  logic [CW-1:0] cnt_q, cnt_d;
  logic long_done_q, long_done_d;
  logic [1:0] evt_q, evt_d;
  logic [1:0] pend_q, pend_d, mode_q;
  logic chg_q, vsync_q, vfall, adv;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'b00 : p + 2'b01;
  endfunction
  assign ks = sync_q[1];
  assign vfall = vsync_q & ~vsync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      evt_q       <= 2'b00;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      evt_q       <= evt_d;
    end
  end
  // one counter serves both debounce windows and the long-press hold timer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    evt_d       = 2'b00;
    unique case (state_q)
      IDLE: if (!ks) begin
        state_d = PRESS_DB;
        cnt_d   = DB_LOAD;
      end
      PRESS_DB: if (ks) state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d     = HELD;
          cnt_d       = LONG_LOAD;
          long_done_d = 1'b0;
        end else cnt_d = cnt_q - 1'b1;
      HELD: if (ks) begin
          state_d = REL_DB;
          cnt_d   = DB_LOAD;
        end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (!long_done_q) begin
          evt_d       = 2'b10;
          long_done_d = 1'b1;
        end
      REL_DB: if (!ks) begin
          state_d = HELD;
          cnt_d   = LONG_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          evt_d   = long_done_q ? 2'b00 : 2'b01;
        end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
`ifdef MODE_AUTOCYCLE_EN
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  logic [FW-1:0] frame_q;
  // a key event in the same cycle wins over the auto-advance
  assign adv = vfall && evt_q == 2'b00 && frame_q == FW'(AUTO_FRAMES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_q <= '0;
    else if (evt_q != 2'b00 || adv) frame_q <= '0;
    else if (vfall) frame_q <= frame_q + 1'b1;
  end
`else
  assign adv = 1'b0;
`endif
  always_comb begin
    pend_d = (evt_q == 2'b01 || adv) ? nxt(pend_q) : (evt_q == 2'b10) ? 2'b00 : pend_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b1;
      pend_q  <= 2'b00;
      mode_q  <= 2'b00;
      chg_q   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      pend_q  <= pend_d;
      mode_q  <= vfall ? pend_q : mode_q;
      chg_q   <= vfall && pend_q != mode_q;
    end
  end
  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign key_evt  = evt_q;
endmodule

// File: tb/tb_mode_select_ctrl.sv
// tb_mode_select_ctrl: directed/randomized button presses checked every cycle against a press-duration model.
module tb_mode_select_ctrl;
  localparam int DB = 8, LG = 64, NM = 4, AF = 3;
  logic clk = 1'b0, rst = 1'b0, key_n = 1'b1, vsync = 1'b1;
  logic [1:0] mode, key_evt;
  logic mode_chg;
  mode_select_ctrl #(.DB_CYCLES(DB), .LONG_CYCLES(LG), .NUM_MODES(NM), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .vsync(vsync),
    .mode(mode), .mode_chg(mode_chg), .key_evt(key_evt));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  int pend_m, mode_m, fcnt_m, prev_evt, exp_evt;
  bit chg_m, vs_last, vfall_m;
  logic [1:0] sched [int];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask
  function automatic int nx(int p);
    return (p + 1) % NM;
  endfunction
  function automatic void model_reset();
    pend_m = 0; mode_m = 0; fcnt_m = 0; prev_evt = 0; exp_evt = 0;
    chg_m = 0; vs_last = 1; vfall_m = 0;
    sched.delete();
  endfunction
  // a press of d low cycles starting after edge c: long event L cycles after debounce
  // entry (c+3), otherwise a short event DB cycles after the synchronized release
  function automatic void sched_press(int c, int d);
    if (d >= LG + 1) sched[c + 3 + LG] = 2'b10;
    else if (d >= DB + 1) sched[c + d + 3 + DB] = 2'b01;
  endfunction
  task automatic step();
    bit vs_now;
    vs_now = vsync;
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) model_reset();
    else begin
      vfall_m = vs_last && !vs_now;
      vs_last = vs_now;
      chg_m = vfall_m && pend_m != mode_m;
      if (vfall_m) mode_m = pend_m;
      if (prev_evt == 1) pend_m = nx(pend_m);
      else if (prev_evt == 2) pend_m = 0;
`ifdef MODE_AUTOCYCLE_EN
      if (prev_evt != 0) fcnt_m = 0;
      else if (vfall_m) begin
        fcnt_m++;
        if (fcnt_m == AF) begin
          fcnt_m = 0;
          pend_m = nx(pend_m);
        end
      end
`endif
      exp_evt = sched.exists(cyc) ? int'(sched[cyc]) : 0;
      prev_evt = exp_evt;
    end
    check("key_evt", key_evt, exp_evt);
    check("mode", mode, mode_m);
    check("mode_chg", mode_chg, chg_m);
    vsync = ((cyc + 1) % 100 >= 98) ? 1'b0 : 1'b1;
  endtask
  task automatic press(int d, int gap);
    sched_press(cyc, d);
    key_n = 1'b0;
    repeat (d) step();
    key_n = 1'b1;
    repeat (gap) step();
  endtask
  task automatic short_press();
    press($urandom_range(12, 50), $urandom_range(15, 40));
  endtask
  task automatic wait_vfall();
    int n = 0;
    do begin
      step();
      n++;
    end while (!vfall_m && n < 200);
    check("vfall_seen", vfall_m, 1);
  endtask
  initial begin
    int c1, n;
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();
    repeat (4) press($urandom_range(1, 5), $urandom_range(10, 20));
    wait_vfall();
`ifndef MODE_AUTOCYCLE_EN
    check("glitch_mode", mode, 0);
`endif
    short_press();
    wait_vfall();
`ifndef MODE_AUTOCYCLE_EN
    check("short_mode", mode, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      short_press();
      wait_vfall();
`ifndef MODE_AUTOCYCLE_EN
      check("wrap_mode", mode, (i + 2) % NM);
`endif
    end
    short_press();
    wait_vfall();
`ifndef MODE_AUTOCYCLE_EN
    check("pre_long_mode", mode, 2);
`endif
    press($urandom_range(70, 200), $urandom_range(20, 40));
    wait_vfall();
    check("long_mode", mode, 0);
    short_press();
    wait_vfall();
    check("pre_coll_mode", mode, 1);
    for (int k = 0; k < 100 && cyc % 100 != 56; k++) step();
    // release lands the short event exactly in the cycle vfall is seen
    press(30, 12);
    check("coll_mode", mode, 1);
    check("coll_chg", mode_chg, 0);
    wait_vfall();
    check("coll_next_mode", mode, 2);
    key_n = 1'b0;
    repeat (20) step();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_mode", mode, 0);
    check("rst_async_chg", mode_chg, 0);
    check("rst_async_evt", key_evt, 0);
    repeat (4) step();
    rst = 1'b1;
    c1 = cyc;
    sched_press(c1, 30);
    repeat (30) step();
    key_n = 1'b1;
    repeat (20) step();
    wait_vfall();
    check("post_rst_mode", mode, mode_m);
    n = 0;
    repeat (950) begin
      step();
      if (mode_chg === 1'b1) n++;
    end
`ifdef MODE_AUTOCYCLE_EN
    check("auto_changes", n, 3);
`else
    check("auto_changes", n, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
